// File: rtl/program_loader.sv
// Program memory loader.
// Receives a framed instruction image as a byte stream while the CPU is held:
//   LEN_HI, LEN_LO (word count N, big-endian), N x {hi, lo}, checksum byte.
// The checksum is the XOR of every preceding frame byte. Each assembled
// 16-bit word is written to consecutive program memory addresses starting
// at START_ADDR. On a good checksum the CPU is released; otherwise a length
// or checksum error is flagged and the CPU stays held.
module program_loader #(
  parameter int unsigned ADDR_BITS  = 11,
  parameter int unsigned DATA_BITS  = 16,
  parameter int unsigned START_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 pm_we,
  output logic [ADDR_BITS-1:0] pm_addr,
  output logic [DATA_BITS-1:0] pm_wdata,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 err_chk,
  output logic                 err_len,
  output logic [ADDR_BITS:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CHECK,
    DONE,
    ERROR
  } state_e;

  // Largest legal word count: the whole memory exactly once.
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_BITS;

  state_e                 state_q,      state_d;
  logic [15:0]            len_q,        len_d;
  logic [7:0]             hi_q,         hi_d;
  logic [7:0]             chk_q,        chk_d;
  logic [ADDR_BITS-1:0]   addr_q,       addr_d;
  logic [ADDR_BITS:0]     wcnt_q,       wcnt_d;
  logic                   pm_we_q,      pm_we_d;
  logic [ADDR_BITS-1:0]   pm_addr_q,    pm_addr_d;
  logic [DATA_BITS-1:0]   pm_wdata_q,   pm_wdata_d;
  logic                   cpu_hold_q,   cpu_hold_d;
  logic                   done_q,       done_d;
  logic                   err_chk_q,    err_chk_d;
  logic                   err_len_q,    err_len_d;

  logic                   accept;
  logic [15:0]            len_full;

  // Byte handshake: only the frame-receiving states consume bytes.
  assign rx_ready = (state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK});
  assign busy     = !(state_q inside {IDLE, DONE, ERROR});
  assign accept   = rx_valid & rx_ready;
  assign len_full = {len_q[15:8], rx_data};

  assign pm_we      = pm_we_q;
  assign pm_addr    = pm_addr_q;
  assign pm_wdata   = pm_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err_chk    = err_chk_q;
  assign err_len    = err_len_q;
  assign word_count = wcnt_q;

  // State register and all datapath registers; reset abandons any load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      hi_q       <= '0;
      chk_q      <= '0;
      addr_q     <= '0;
      wcnt_q     <= '0;
      pm_we_q    <= 1'b0;
      pm_addr_q  <= '0;
      pm_wdata_q <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_chk_q  <= 1'b0;
      err_len_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q    <= state_d;
      len_q      <= len_d;
      hi_q       <= hi_d;
      chk_q      <= chk_d;
      addr_q     <= addr_d;
      wcnt_q     <= wcnt_d;
      pm_we_q    <= pm_we_d;
      pm_addr_q  <= pm_addr_d;
      pm_wdata_q <= pm_wdata_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_chk_q  <= err_chk_d;
      err_len_q  <= err_len_d;
    end
  end

  // Next-state and datapath update for the frame parser.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    len_d      = len_q;
    hi_d       = hi_q;
    chk_d      = chk_q;
    addr_d     = addr_q;
    wcnt_d     = wcnt_q;
    pm_we_d    = 1'b0;
    pm_addr_d  = pm_addr_q;
    pm_wdata_d = pm_wdata_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    err_chk_d  = err_chk_q;
    err_len_d  = err_len_q;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d    = LEN_HI;
          done_d     = 1'b0;
          err_chk_d  = 1'b0;
          err_len_d  = 1'b0;
          wcnt_d     = '0;
          chk_d      = '0;
          cpu_hold_d = 1'b1;
          addr_d     = ADDR_BITS'(START_ADDR);
        end
      end

      LEN_HI: begin
        if (accept) begin
          len_d[15:8] = rx_data;
          chk_d       = chk_q ^ rx_data;
          state_d     = LEN_LO;
        end
      end

      LEN_LO: begin
        if (accept) begin
          len_d = len_full;
          chk_d = chk_q ^ rx_data;
          if (32'(len_full) > MAX_WORDS) begin
            state_d   = ERROR;
            err_len_d = 1'b1;
          end else if (len_full == 16'd0) begin
            state_d = CHECK;
          end else begin
            state_d = DATA_HI;
          end
        end
      end

      DATA_HI: begin
        if (accept) begin
          hi_d    = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = DATA_LO;
        end
      end

      DATA_LO: begin
        if (accept) begin
          chk_d      = chk_q ^ rx_data;
          pm_we_d    = 1'b1;
          pm_addr_d  = addr_q;
          pm_wdata_d = DATA_BITS'({hi_q, rx_data});
          addr_d     = addr_q + 1'b1;
          wcnt_d     = wcnt_q + 1'b1;
          state_d    = (32'(wcnt_d) == 32'(len_q)) ? CHECK : DATA_HI;
        end
      end

      CHECK: begin
        if (accept) begin
          if (rx_data == chk_q) begin
            state_d    = DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d   = ERROR;
            err_chk_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader. Two instances share the byte
// stream: index 0 loads from address 0, index 1 from 2040 for the
// wrap-around case. Expected writes are queued as bytes are driven and
// popped by a monitor when the selected instance strobes pm_we.
`timescale 1ns/1ps
module tb_program_loader;

  localparam int AB = 11;

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_s[2];
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rdy[2];
  logic          we[2];
  logic [AB-1:0] addr[2];
  logic [15:0]   wd[2];
  logic          hold[2];
  logic          busy[2];
  logic          done[2];
  logic          ec[2];
  logic          el[2];
  logic [AB:0]   wc[2];

  program_loader #(.ADDR_BITS(AB), .DATA_BITS(16), .START_ADDR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rdy[0]), .pm_we(we[0]), .pm_addr(addr[0]),
    .pm_wdata(wd[0]), .cpu_hold(hold[0]), .busy(busy[0]), .done(done[0]),
    .err_chk(ec[0]), .err_len(el[0]), .word_count(wc[0])
  );

  program_loader #(.ADDR_BITS(AB), .DATA_BITS(16), .START_ADDR(2040)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rdy[1]), .pm_we(we[1]), .pm_addr(addr[1]),
    .pm_wdata(wd[1]), .cpu_hold(hold[1]), .busy(busy[1]), .done(done[1]),
    .err_chk(ec[1]), .err_len(el[1]), .word_count(wc[1])
  );

  always #5 clk = ~clk;

  int            sel = 0;
  int            n_vec = 0;
  int            n_err = 0;
  int            n_wr = 0;
  wr_t           sb[$];
  wr_t           mon_e;
  logic [AB-1:0] exp_addr = '0;
  logic [15:0]   wq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && we[sel]) begin
      n_wr++;
      if (sb.size() == 0) begin
        check("stray_pm_we", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("pm_addr", 32'(addr[sel]), 32'(mon_e.addr));
        check("pm_wdata", 32'(wd[sel]), 32'(mon_e.data));
      end
    end
  end

  // All tasks begin and end 1 ns after a rising edge (or mid-cycle).
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit r;
    bit ok;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      r = rdy[sel];
      @(posedge clk); #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    rx_valid = 1'b0;
    if (!ok) check("rx_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start_s[sel] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
  endtask

  task automatic start_load();
    pulse_start();
    exp_addr = (sel == 1) ? AB'(2040) : AB'(0);
    n_wr = 0;
    check("start_busy", 32'(busy[sel]), 32'd1);
    check("start_hold", 32'(hold[sel]), 32'd1);
    check("start_done_clr", 32'(done[sel]), 32'd0);
  endtask

  // Sends a complete frame of n words from wq; optionally corrupts the
  // checksum, inserts random gaps, and pulses start mid-frame.
  task automatic send_frame(input int n, input bit bad, input int maxgap, input bit poke);
    logic [7:0]  c;
    logic [15:0] nn;
    logic [15:0] w;
    c  = 8'h00;
    nn = 16'(n);
    send_byte(nn[15:8], $urandom_range(maxgap, 0)); c ^= nn[15:8];
    send_byte(nn[7:0],  $urandom_range(maxgap, 0)); c ^= nn[7:0];
    for (int i = 0; i < n; i++) begin
      w = wq[i];
      send_byte(w[15:8], $urandom_range(maxgap, 0)); c ^= w[15:8];
      if (poke && i == 0) pulse_start();
      sb.push_back(wr_t'{exp_addr, w});
      exp_addr = exp_addr + 1'b1;
      send_byte(w[7:0], $urandom_range(maxgap, 0)); c ^= w[7:0];
    end
    send_byte(bad ? (c ^ 8'h01) : c, $urandom_range(maxgap, 0));
    @(negedge clk); #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;

    // Reset state
    #12;
    check("rst_flags", {31'd0, rdy[0] | we[0] | hold[0] | busy[0] | done[0] | ec[0] | el[0]}, 32'd0);
    check("rst_wc", 32'(wc[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal load: 00 02 12 34 AB CD, checksum 0x42
    wq = '{16'h1234, 16'hABCD};
    start_load();
    send_frame(2, 1'b0, 0, 1'b0);
    check("nom_done", 32'(done[0]), 32'd1);
    check("nom_hold", 32'(hold[0]), 32'd0);
    check("nom_busy", 32'(busy[0]), 32'd0);
    check("nom_wc", 32'(wc[0]), 32'd2);
    check("nom_nwr", 32'(n_wr), 32'd2);
    check("nom_errs", {30'd0, ec[0], el[0]}, 32'd0);

    // Bad checksum: writes still happen, error flagged, CPU held
    start_load();
    send_frame(2, 1'b1, 0, 1'b0);
    check("bad_err_chk", 32'(ec[0]), 32'd1);
    check("bad_done", 32'(done[0]), 32'd0);
    check("bad_hold", 32'(hold[0]), 32'd1);
    check("bad_busy", 32'(busy[0]), 32'd0);
    check("bad_nwr", 32'(n_wr), 32'd2);

    // Zero-length frame: 00 00 00
    start_load();
    check("zero_err_clr", 32'(ec[0]), 32'd0);
    send_frame(0, 1'b0, 0, 1'b0);
    check("zero_done", 32'(done[0]), 32'd1);
    check("zero_nwr", 32'(n_wr), 32'd0);
    check("zero_wc", 32'(wc[0]), 32'd0);

    // Oversize length 2049
    start_load();
    send_byte(8'h08, 0);
    send_byte(8'h01, 0);
    check("ovr_err_len", 32'(el[0]), 32'd1);
    check("ovr_busy", 32'(busy[0]), 32'd0);
    check("ovr_done", 32'(done[0]), 32'd0);
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("ovr_rx_ready", 32'(rdy[0]), 32'd0);
    end
    rx_valid = 1'b0;
    @(posedge clk); #1;
    check("ovr_nwr", 32'(n_wr), 32'd0);

    // Back-pressure with an ignored mid-frame start
    wq = '{16'h1234, 16'hABCD};
    start_load();
    send_frame(2, 1'b0, 3, 1'b1);
    check("bp_done", 32'(done[0]), 32'd1);
    check("bp_wc", 32'(wc[0]), 32'd2);
    check("bp_nwr", 32'(n_wr), 32'd2);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Reset after the first word is written
    start_load();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    sb.push_back(wr_t'{AB'(0), 16'h1234});
    send_byte(8'h34, 0);
    @(negedge clk); #1;
    check("mid_nwr", 32'(n_wr), 32'd1);
    send_byte(8'hAB, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {31'd0, rdy[0] | we[0] | hold[0] | busy[0] | done[0] | ec[0] | el[0]}, 32'd0);
    check("mid_rst_addr", 32'(addr[0]), 32'd0);
    check("mid_rst_wdata", 32'(wd[0]), 32'd0);
    check("mid_rst_wc", 32'(wc[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    wq = '{16'h1234, 16'hABCD};
    start_load();
    send_frame(2, 1'b0, 0, 1'b0);
    check("post_rst_done", 32'(done[0]), 32'd1);
    check("post_rst_nwr", 32'(n_wr), 32'd2);

    // Full memory from 2040: address wraps 2047 -> 0
    sel = 1;
    wq.delete();
    for (int i = 0; i < 2048; i++) wq.push_back(16'(i * 40503 + 23));
    start_load();
    send_frame(2048, 1'b0, 0, 1'b0);
    check("full_done", 32'(done[1]), 32'd1);
    check("full_wc", 32'(wc[1]), 32'd2048);
    check("full_nwr", 32'(n_wr), 32'd2048);
    check("full_last_addr", 32'(addr[1]), 32'd2039);
    check("full_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer-side counterpart of the program memory: fills program memory with a new instruction image received as a byte stream (from the UART receiver) while the CPU is held.
- Frames the incoming bytes, assembles 16-bit instruction words and issues one write per word at consecutive addresses.
- Verifies length and checksum, then releases the CPU or flags an error.

Parameters:
- ADDR_BITS, 11, program memory address width
- DATA_BITS, 16, instruction width; fixed at 2 bytes per word
- START_ADDR, 0, first address written

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse: begin a load; ignored while busy=1
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts a byte this cycle
- pm_we  output  1  program memory write strobe, one cycle per word
- pm_addr  output  ADDR_BITS  write address
- pm_wdata  output  DATA_BITS  write data
- cpu_hold  output  1  CPU stall/hold request
- busy  output  1  load in progress
- done  output  1  last load succeeded
- err_chk  output  1  last load failed on checksum
- err_len  output  1  last load failed on length
- word_count  output  ADDR_BITS+1  words written in the current/last load

Behaviour:
- Reset: clock and reset are as stated above (one clock; rst_n asynchronous, active-low). While rst_n=0, all outputs are 0, the state is IDLE and the checksum and counters are cleared. Reset mid-load abandons the load: words already written stay in memory, and no further writes occur.
- Byte acceptance: a byte is accepted when rx_valid & rx_ready at a rising clk edge. rx_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words each as hi byte then lo byte, then one checksum byte. The checksum byte is the XOR of all preceding frame bytes, including the length bytes.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + start -> LEN_HI. On this transition: clear done, err_chk, err_len, word_count and the checksum; set busy=1 and cpu_hold=1; load the address counter with START_ADDR.
- LEN_HI -> LEN_LO on an accepted byte.
- LEN_LO, on an accepted byte, evaluates N:
  - N > 2^ADDR_BITS -> ERROR with err_len=1.
  - N = 0 -> CHECK.
  - otherwise -> DATA_HI.
- DATA_HI -> DATA_LO on an accepted byte; the byte is latched as the high byte.
- DATA_LO, on an accepted byte:
  - The following cycle: pm_we=1 for exactly one cycle, pm_wdata={hi,lo}, pm_addr=current address.
  - The address counter increments after the write and wraps modulo 2^ADDR_BITS.
  - word_count increments.
  - Next state is CHECK if word_count reaches N, else DATA_HI.
- CHECK, on an accepted byte:
  - byte equals the running XOR -> DONE with done=1 and cpu_hold=0.
  - otherwise -> ERROR with err_chk=1; cpu_hold stays 1.
- busy=1 in every state except IDLE, DONE and ERROR.
- done, err_chk and err_len hold until the next accepted start.
- pm_we is never asserted outside the write cycle that follows a DATA_LO acceptance. pm_addr and pm_wdata hold their last values otherwise.
- A start pulse received while busy=1 has no effect.
- rx_valid while rx_ready=0 is ignored; the byte is not consumed.
- Latency: accepted final checksum byte -> done/err flag 1 cycle later. Accepted lo byte -> pm_we 1 cycle later.

Test Plan:
- Nominal load:
  - Stimulus: start, bytes 00 02 12 34 AB CD, then checksum = 00^02^12^34^AB^CD = 0x42.
  - Response: writes 0x1234@0 and 0xABCD@1, one pm_we each; done=1, cpu_hold=0, word_count=2.
- Bad checksum:
  - Stimulus: same frame with checksum 0x43.
  - Response: both writes occur; err_chk=1, done=0, cpu_hold=1, busy=0.
- Zero and oversize length:
  - Stimulus: frame 00 00 00.
  - Response: no pm_we; done=1.
  - Stimulus: length 08 01 (2049).
  - Response: err_len=1 after LEN_LO; rx_ready=0 afterwards.
- Back-pressure and ignored start:
  - Stimulus: rx_valid toggling with gaps; start pulsed mid-frame.
  - Response: identical writes to the nominal load; frame unaffected.
- Reset mid-load:
  - Stimulus: drop rst_n after the first word is written.
  - Response: all outputs 0 asynchronously. A following nominal frame loads correctly from START_ADDR.
- Full memory with START_ADDR=2040:
  - Stimulus: N=2048.
  - Response: address wraps 2047 -> 0; word_count=2048; done=1.
